// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: debounce states,
// row strobe reset pattern, frame result encoding and the index-to-keycap table.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } kp_state_e;

    localparam logic [3:0] ROW_RESET = 4'b1110;

    // Result of one full scan frame; hit=0 means no key was seen.
    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } frame_res_t;

    localparam frame_res_t FRAME_NONE = '{hit: 1'b0, idx: 4'd0};

    // Keycap legend by matrix index (row*4+col); '*' reports as E, '#' as F.
    localparam logic [3:0] KEY_CODE_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] key_code_of(input logic [3:0] idx);
        return KEY_CODE_MAP[idx];
    endfunction

endpackage

// File: rtl/keypad_encoder.sv
// Combinational column encoder: turns the active-low column readback of one
// strobed row into a matrix index, lowest column winning.
module keypad_encoder
    import keypad_pkg::*;
(
    input  logic [1:0] row_idx_i,
    input  logic [3:0] col_n_i,
    output logic       hit_o,
    output logic [3:0] index_o
);

    logic [1:0] col_idx;

    always_comb begin
        col_idx = 2'd0;
        // Scan downwards so the lowest pressed column is the last assignment.
        for (int c = 3; c >= 0; c--) begin
            if (!col_n_i[c]) begin
                col_idx = 2'(c);
            end
        end
    end

    assign hit_o   = ~&col_n_i;
    assign index_o = {row_idx_i, col_idx};

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, column synchronisation, per-frame
// lowest-key resolution, frame-based debounce and a one-entry output buffer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W     = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);

    localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

    logic [3:0]            col_meta_q;
    logic [3:0]            col_sync_q;
    logic [SCAN_DIV_W-1:0] div_q;
    logic [3:0]            row_n_q;
    logic [1:0]            row_idx_q;
    frame_res_t            acc_q;

    logic       tick;
    logic       frame_end;
    logic       enc_hit;
    logic [3:0] enc_idx;
    frame_res_t frame_cur;

    kp_state_e  state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic       emit;
    logic [3:0] emit_idx;

    logic       key_valid_q, key_valid_d;
    logic [3:0] key_code_q, key_code_d;
    logic       overflow_q, overflow_d;
    logic       key_held_q, key_held_d;
    logic       consume;

    assign tick      = &div_q;
    assign frame_end = tick && (row_idx_q == 2'd3);

    keypad_encoder u_encoder (
        .row_idx_i (row_idx_q),
        .col_n_i   (col_sync_q),
        .hit_o     (enc_hit),
        .index_o   (enc_idx)
    );

    // Rows are visited in ascending order, so the first hit in a frame is
    // already the lowest index; later rows only fill in when nothing was seen.
    always_comb begin
        frame_cur = (row_idx_q == 2'd0) ? FRAME_NONE : acc_q;
        if (!frame_cur.hit && enc_hit) begin
            frame_cur = '{hit: 1'b1, idx: enc_idx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
            div_q      <= '0;
            row_n_q    <= ROW_RESET;
            row_idx_q  <= 2'd0;
            acc_q      <= FRAME_NONE;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
            div_q      <= div_q + 1'b1;
            if (tick) begin
                acc_q     <= frame_cur;
                row_n_q   <= {row_n_q[2:0], row_n_q[3]};
                row_idx_q <= row_idx_q + 2'd1;
            end
        end
    end

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        emit     = 1'b0;
        emit_idx = cand_q;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_cur.hit) begin
                        cand_d = frame_cur.idx;
                        cnt_d  = 4'd1;
                        if (DB_N == 4'd1) begin
                            emit     = 1'b1;
                            emit_idx = frame_cur.idx;
                            state_d  = HELD;
                        end else begin
                            state_d = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (!frame_cur.hit) begin
                        state_d = IDLE;
                    end else if (frame_cur.idx == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_N) begin
                            emit    = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        cand_d = frame_cur.idx;
                        cnt_d  = 4'd1;
                    end
                end
                HELD: begin
                    // A single empty frame already satisfies a debounce depth of 1.
                    if (!frame_cur.hit) begin
                        cnt_d   = 4'd1;
                        state_d = (DB_N == 4'd1) ? IDLE : RELEASE_CHK;
                    end
                end
                RELEASE_CHK: begin
                    if (frame_cur.hit) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_N) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign consume    = key_valid_q & key_ready;
    assign key_held_d = (state_d == HELD) || (state_d == RELEASE_CHK);

    always_comb begin
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        overflow_d  = overflow_q;
        if (consume) begin
            key_valid_d = 1'b0;
        end
        if (emit) begin
            if (!key_valid_q || consume) begin
                key_code_d  = key_code_of(emit_idx);
                key_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            overflow_q  <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            overflow_q  <= overflow_d;
            key_held_q  <= key_held_d;
        end
    end

    assign row_n     = row_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a frame-level keypad model predicts
// emitted keys, key_held and overflow; a monitor checks every handshake.
module tb_keypad_scanner;

    localparam int SDW   = 4;
    localparam int DB    = 2;
    localparam int FRAME = 4 * (1 << SDW);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       key_held;
    logic       overflow;
    logic [15:0] pressed = 16'h0;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];
    logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    // Reference state: last frame result, its run length, and buffer/hold flags.
    int m_prev;
    int m_run;
    bit m_held;
    bit m_full;
    bit m_ovf;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV_W(SDW), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    // Physical keypad: a pressed key shorts its column low while its row is strobed.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [15:0] p);
        for (int i = 0; i < 16; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = -1;
        m_run  = 0;
        m_held = 0;
        m_full = 0;
        m_ovf  = 0;
        exp_q.delete();
    endtask

    // One scan frame seen by the model: a key is accepted after DB identical
    // frames while not held, and released after DB empty frames.
    task automatic model_frame(input logic [15:0] p);
        int r;
        r = lowest(p);
        if (r == m_prev) m_run++;
        else begin
            m_run  = 1;
            m_prev = r;
        end
        if (!m_held && r >= 0 && m_run == DB) begin
            m_held = 1;
            if (m_full && !key_ready) m_ovf = 1;
            else begin
                exp_q.push_back(code_tab[r]);
                m_full = !key_ready;
            end
        end else if (m_held && r < 0 && m_run == DB) begin
            m_held = 0;
        end
    endtask

    task automatic set_ready(input logic v);
        key_ready = v;
        if (v) m_full = 0;
    endtask

    // Holds a press pattern for n whole frames, starting just after a frame end.
    task automatic hold(input logic [15:0] p, input int n);
        pressed = p;
        repeat (n) begin
            model_frame(p);
            repeat (FRAME) @(posedge clk);
            #1;
            check("key_held", key_held, m_held);
            check("overflow", overflow, m_ovf);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        pressed = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_row_n", row_n, 4'b1110);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        model_reset();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_key got=%0h required=none at %0t", key_code, $time);
            end else begin
                check("key_code", key_code, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] p;
        int kind;

        // Reset and row rotation timing.
        do_reset();
        model_frame(16'h0);
        repeat (16) @(posedge clk);
        #1;
        check("row_after_16", row_n, 4'b1101);
        repeat (FRAME - 16) @(posedge clk);
        #1;
        check("row_after_64", row_n, 4'b1110);
        check("key_held", key_held, m_held);

        // '5' pressed and released.
        hold(16'h1 << 5, 3);
        hold(16'h0, 3);

        // One-frame bounce on '9'.
        hold(16'h1 << 10, 1);
        hold(16'h0, 2);

        // Long hold of '*', short release, then '#'.
        hold(16'h1 << 12, 20);
        hold(16'h0, 2);
        hold(16'h1 << 14, 3);
        hold(16'h0, 3);

        // Consumer stalled: '1' buffered, '2' dropped.
        set_ready(1'b0);
        hold(16'h1 << 0, 3);
        hold(16'h0, 3);
        hold(16'h1 << 1, 3);
        hold(16'h0, 3);
        check("stall_key_valid", key_valid, 1'b1);
        check("stall_key_code", key_code, 4'h1);
        check("stall_overflow", overflow, 1'b1);
        model_frame(16'h0);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        check("drain_key_valid", key_valid, 1'b0);
        check("drain_key_code", key_code, 4'h1);
        repeat (FRAME - 1) @(posedge clk);
        #1;

        // Simultaneous '3' and '7': lowest index wins.
        hold((16'h1 << 2) | (16'h1 << 8), 3);
        hold(16'h0, 3);

        // Reset while a press is still being debounced.
        hold(16'h1 << 9, 1);
        repeat (FRAME / 2) @(posedge clk);
        #1;
        do_reset();
        hold(16'h1 << 9, 3);
        hold(16'h0, 3);

        // Random press patterns with occasional consumer stalls.
        for (int seg = 0; seg < 40; seg++) begin
            kind = $urandom_range(0, 3);
            p = 16'h0;
            if (kind != 0) p[$urandom_range(0, 15)] = 1'b1;
            if (kind == 3) p[$urandom_range(0, 15)] = 1'b1;
            set_ready($urandom_range(0, 3) != 0);
            hold(p, $urandom_range(1, 4));
        end
        set_ready(1'b1);
        hold(16'h0, 4);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_keys got=%0d required=0 pending", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and reports each debounced keypress as a hex key code through a valid/ready handshake.
- Input-side counterpart of the multiplexed seven-segment driver. Rows are strobed active-low in rotation at the same divided rate the display uses for its anode strobes.
- Columns are read back, encoded to a nibble, debounced over whole scan frames, then buffered for the consumer (e.g. display/ASCII logic).

Parameters:
SCAN_DIV_W, 16, width of the row-strobe divider; one scan tick every 2^SCAN_DIV_W clk cycles
DEBOUNCE_SCANS, 4, consecutive identical frames needed to accept a press or a release (min 1, max 15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
col_n  input  4  keypad columns, active-low, externally pulled up, asynchronous
row_n  output  4  row strobes, active-low one-hot
key_code  output  4  code of the buffered key
key_valid  output  1  key_code holds an unconsumed key
key_ready  input  1  consumer accepts key_code when high with key_valid
key_held  output  1  a key is currently held (debounced)
overflow  output  1  sticky; a press was dropped because the buffer was full

Behaviour:
- Reset (sync, active-high, clk edge): div=0, row_n=4'b1110, state IDLE, debounce count=0, key_code=0, key_valid=0, key_held=0, overflow=0. A reset mid-scan or mid-debounce discards all partial results.
- Synchroniser: two flops on col_n. Only the synchronised value is used.
- Divider: div increments every cycle and wraps. Tick = (div == all ones).
- On a tick:
  - Sample the synced columns for the current row.
  - Then rotate row_n left: {row_n[2:0],row_n[3]}.
  - Each row is therefore driven a full 2^SCAN_DIV_W cycles before sampling.
- Frame: 4 ticks, rows 0..3. A frame ends on the tick that samples row 3.
- Frame result: NONE, or index = row*4+col of the lowest-index pressed key. Multiple keys resolve to the lowest index.
- Code map (index -> code): 0:1 1:2 2:3 3:A 4:4 5:5 6:6 7:B 8:7 9:8 10:9 11:C 12:E(*) 13:0 14:F(#) 15:D.
- Debounce FSM, evaluated only at frame end:
  - IDLE: key k -> PRESS_CHK, cand=k, cnt=1. If DEBOUNCE_SCANS=1, emit immediately and go to HELD.
  - PRESS_CHK:
    - same k -> cnt+1; at cnt==DEBOUNCE_SCANS, emit cand and go to HELD.
    - different key -> cand=new, cnt=1.
    - NONE -> IDLE.
  - HELD: NONE -> RELEASE_CHK, cnt=1; any key -> stay. No auto-repeat, and a different key does not emit.
  - RELEASE_CHK: NONE -> cnt+1; at cnt==DEBOUNCE_SCANS go to IDLE. Any key -> HELD.
- key_held = state in {HELD, RELEASE_CHK}, registered.
- Output buffer (one entry):
  - Consume: key_valid & key_ready clears key_valid next cycle.
  - Emit when buffer empty, or when it is being consumed in the same cycle: load key_code and set key_valid.
  - Emit while full and not consumed: key_code and key_valid unchanged, overflow<=1. overflow clears only on rst.
- Latency: once a key is stable, key_valid rises in the cycle after the frame-end tick of the DEBOUNCE_SCANS-th matching frame. Worst case is (DEBOUNCE_SCANS+1)*4*2^SCAN_DIV_W + 3 cycles.

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum (IDLE, PRESS_CHK, HELD, RELEASE_CHK)
  - row reset constant 4'b1110
  - 16-entry index->code constant table
  - NONE encoding for the frame result
- Sub-module keypad_encoder: combinational; takes row index (2) and synced columns (4); outputs hit (1) and index (4) with lowest-column priority. It is the inverse-direction sibling of the segment decoder.
- Top keeps the divider, synchroniser, frame accumulator, FSM and output buffer.

Test Plan:
Bench setup: SCAN_DIV_W=4 (tick every 16 cycles, frame 64), DEBOUNCE_SCANS=2. The keypad model drives col_n[c]=0 while row_n[r]=0 for each pressed (r,c).
- Reset: hold rst 3 cycles -> row_n=1110, key_valid=0, overflow=0, key_held=0. 16 cycles after release -> row_n=1101; 64 cycles -> back to 1110.
- Press '5' (r1,c1) with key_ready=1 -> exactly one 1-cycle key_valid with key_code=4'h5 within 3 frames; key_held=1 while pressed, 0 two frames after release.
- Bounce: press '9' for one frame, release -> key_valid never asserts; FSM returns IDLE.
- Hold '*' 20 frames, release 2 frames, press '#' -> exactly two keys: E then F.
- key_ready=0: press/release '1', then press/release '2' -> key_valid=1, key_code=1, overflow=1. Then key_ready=1 -> key_valid=0 next cycle and key_code stays 1.
- Simultaneous '3' and '7' -> key_code=3. Separately, assert rst in PRESS_CHK -> no emission; keypad re-detected from IDLE afterwards.
